seg_capture_display: RTL

//  Captures NUM_DIGITS consecutive words from the SDRAM read-data stream after a start request.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg7_decode.sv | 15 +
 rtl/seg_capture_display.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment capture display.
package seg_pkg;

    // Capture controller states
    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        CAPTURE,
        HOLD
    } state_t;

    // Active-low code with every segment off
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} codes for hex 0..F; entry 0 sits in the lowest slice
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low 7-segment decoder with a blank override.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank wins over the table lookup
    always_comb begin
        seg = blank ? SEG_BLANK : SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg_capture_display.sv
// Captures NUM_DIGITS words from the SDRAM read stream after a start request
// and shows their low nibbles on active-low 7-segment digits.
// Optional build macro: SEG_LZ_BLANK_EN enables leading-zero blanking.
module seg_capture_display
    import seg_pkg::*;
#(
    parameter int DATA_W      = 6,
    parameter int NUM_DIGITS  = 4,
    parameter int START_DELAY = 2
) (
    input  logic                    clk,
    input  logic                    s_rst_n,
    input  logic                    key,
    input  logic                    start,
    input  logic                    rd_valid,
    input  logic [DATA_W-1:0]       rd,
    output logic [NUM_DIGITS*7-1:0] h,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t                       state, state_nxt;
    logic [CNT_W-1:0]             cnt, cnt_nxt;
    logic [IDX_W-1:0]             idx, idx_nxt;
    logic                         done_nxt;
    logic                         wr_en;
    logic                         clr;
    logic [NUM_DIGITS-1:0][3:0]   nibbles;
    logic [NUM_DIGITS-1:0]        valid;
    logic [NUM_DIGITS-1:0]        blank;
    logic                         unused_rd;

    // Only the low nibble of each read word is displayed
    assign unused_rd = ^rd;

    assign busy = (state == DELAY) || (state == CAPTURE);

    // Next-state logic; key low aborts everything, start is honoured only when not busy
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        done_nxt  = 1'b0;
        wr_en     = 1'b0;
        clr       = 1'b0;
        if (!key) begin
            state_nxt = IDLE;
            clr       = 1'b1;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (start) begin
                        idx_nxt = '0;
                        if (START_DELAY == 0) begin
                            state_nxt = CAPTURE;
                        end else begin
                            state_nxt = DELAY;
                            cnt_nxt   = CNT_W'(START_DELAY);
                        end
                    end
                end
                DELAY: begin
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = CAPTURE;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    if (rd_valid) begin
                        wr_en = 1'b1;
                        if (idx == LAST_IDX) begin
                            state_nxt = HOLD;
                            done_nxt  = 1'b1;
                        end else begin
                            idx_nxt = idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // State, counters, done pulse and the captured digit store
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            done    <= 1'b0;
            nibbles <= '0;
            valid   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            done  <= done_nxt;
            if (clr) begin
                valid <= '0;
            end else if (wr_en) begin
                nibbles[idx] <= rd[3:0];
                valid[idx]   <= 1'b1;
            end
        end
    end

`ifdef SEG_LZ_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero or not yet captured
    logic [NUM_DIGITS-1:0] zero_or_off;
    logic                  unused_lz_lsd;

    assign unused_lz_lsd = zero_or_off[0];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lz
        assign zero_or_off[g] = ~valid[g] | (nibbles[g] == 4'd0);
        if (g == 0) begin : g_lsd
            assign blank[g] = ~valid[g];
        end else begin : g_hi
            assign blank[g] = ~valid[g] | (&zero_or_off[NUM_DIGITS-1:g]);
        end
    end
`else
    assign blank = ~valid;
`endif

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        seg7_decode u_dec (
            .nibble (nibbles[g]),
            .blank  (blank[g]),
            .seg    (h[7*g +: 7])
        );
    end

endmodule
